// File: rtl/instr_fetch.sv
// RV32I instruction fetch: owns the PC, issues credit-limited word reads, buffers responses for decode.
// Optional build macro IFU_MISALIGN_CHECK_EN adds the misaligned-redirect fault entry and the HALT state.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic        inst_misalign
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    ST_HALT  = 2'd2
`endif
  } state_t;

  state_t          state_r, state_s;
  logic [31:0]     pc_r;
  logic [CW-1:0]   outst_r, outst_s, stale_r, stale_s, cnt_r;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r, pq_wr_r, pq_rd_r;
  logic [31:0]     data_mem_r [DEPTH];
  logic [31:0]     pc_mem_r   [DEPTH];
  logic [31:0]     pq_mem_r   [DEPTH];
  logic            req_fire_s, resp_keep_s, pop_s, push_s, push_mis_s;
  logic [31:0]     push_data_s, push_pc_s, redir_pc_s, fault_pc_s;
  logic            redir_mis_s, halt_pend_s, fault_push_s;

`ifdef IFU_MISALIGN_CHECK_EN
  logic            fault_pend_r, halt_pend_r;
  logic [31:0]     fault_pc_r;
  logic            mis_mem_r [DEPTH];

  assign redir_pc_s   = redirect_pc;
  assign redir_mis_s  = (redirect_pc[1:0] != 2'b00);
  assign halt_pend_s  = halt_pend_r;
  assign fault_pc_s   = fault_pc_r;
  assign fault_push_s = (state_r == ST_HALT) && fault_pend_r && !redirect_valid;
  assign inst_misalign = inst_valid && mis_mem_r[rd_ptr_r];
`else
  assign redir_pc_s   = redirect_pc & 32'hFFFF_FFFC;
  assign redir_mis_s  = 1'b0;
  assign halt_pend_s  = 1'b0;
  assign fault_pc_s   = 32'h0000_0000;
  assign fault_push_s = 1'b0;
`endif

  // Stale responses never pop the pc queue; a redirect flushes everything in the same cycle.
  assign imem_req_valid = !rst && (state_r == ST_FETCH) && ((cnt_r + outst_r) < CNT_DEPTH);
  assign imem_req_addr  = pc_r;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign resp_keep_s    = imem_resp_valid && (stale_r == CNT_ZERO) && !redirect_valid;
  assign pop_s          = inst_valid && inst_ready && !redirect_valid;
  assign inst_valid     = !rst && (cnt_r != CNT_ZERO);
  assign inst_data      = rst ? 32'h0000_0000 : data_mem_r[rd_ptr_r];
  assign inst_pc        = rst ? 32'h0000_0000 : pc_mem_r[rd_ptr_r];

  // In-flight and stale counters; stale snapshots outstanding after this cycle's traffic.
  always_comb begin
    outst_s = outst_r + (req_fire_s ? CNT_ONE : CNT_ZERO) - (imem_resp_valid ? CNT_ONE : CNT_ZERO);
    if (redirect_valid) begin
      stale_s = outst_s;
    end else if (imem_resp_valid && (stale_r != CNT_ZERO)) begin
      stale_s = stale_r - CNT_ONE;
    end else begin
      stale_s = stale_r;
    end
  end

  // FIFO write source: a memory response or the synthetic fault entry.
  always_comb begin
    push_s = resp_keep_s || fault_push_s;
    if (fault_push_s) begin
      push_data_s = 32'h0000_0000;
      push_pc_s   = fault_pc_s;
      push_mis_s  = 1'b1;
    end else begin
      push_data_s = imem_resp_data;
      push_pc_s   = pq_mem_r[pq_rd_r];
      push_mis_s  = 1'b0;
    end
  end

  // Next-state logic; redirect overrides every state.
  always_comb begin
    state_s = state_r;
    if (redirect_valid) begin
      if (stale_s != CNT_ZERO) begin
        state_s = ST_DRAIN;
`ifdef IFU_MISALIGN_CHECK_EN
      end else if (redir_mis_s) begin
        state_s = ST_HALT;
`endif
      end else begin
        state_s = ST_FETCH;
      end
    end else begin
      case (state_r)
        ST_FETCH: state_s = ST_FETCH;
        ST_DRAIN: begin
          if (stale_s != CNT_ZERO) begin
            state_s = ST_DRAIN;
`ifdef IFU_MISALIGN_CHECK_EN
          end else if (halt_pend_s) begin
            state_s = ST_HALT;
`endif
          end else begin
            state_s = ST_FETCH;
          end
        end
`ifdef IFU_MISALIGN_CHECK_EN
        ST_HALT:  state_s = ST_HALT;
`endif
        default:  state_s = ST_FETCH;
      endcase
    end
  end

  // State, PC and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      outst_r <= CNT_ZERO;
      stale_r <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      outst_r <= outst_s;
      stale_r <= stale_s;
      if (redirect_valid) begin
        pc_r <= redir_pc_s;
      end else if (req_fire_s) begin
        pc_r <= pc_r + 32'd4;
      end
    end
  end

  // Instruction buffer toward decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]   <= 32'h0000_0000;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= CNT_ZERO;
    end else if (redirect_valid) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= CNT_ZERO;
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= push_data_s;
        pc_mem_r[wr_ptr_r]   <= push_pc_s;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      cnt_r <= cnt_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
    end
  end

  // Request-address queue pairing each live response with its PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pq_mem_r[i] <= 32'h0000_0000;
      end
      pq_wr_r <= '0;
      pq_rd_r <= '0;
    end else if (redirect_valid) begin
      pq_wr_r <= '0;
      pq_rd_r <= '0;
    end else begin
      if (req_fire_s) begin
        pq_mem_r[pq_wr_r] <= pc_r;
        pq_wr_r           <= pq_wr_r + PTR_ONE;
      end
      if (resp_keep_s) begin
        pq_rd_r <= pq_rd_r + PTR_ONE;
      end
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  // Misaligned-target fault bookkeeping and per-entry fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mis_mem_r[i] <= 1'b0;
      end
      fault_pend_r <= 1'b0;
      halt_pend_r  <= 1'b0;
      fault_pc_r   <= 32'h0000_0000;
    end else begin
      if (push_s) begin
        mis_mem_r[wr_ptr_r] <= push_mis_s;
      end
      if (redirect_valid) begin
        fault_pend_r <= redir_mis_s;
        halt_pend_r  <= redir_mis_s;
        fault_pc_r   <= redirect_pc;
      end else if (fault_push_s) begin
        fault_pend_r <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model with programmable latency/ready, scoreboard of expected {pc, data}.
// Define IFU_MISALIGN_CHECK_EN for both files to exercise the misaligned-redirect phase.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        inst_misalign;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef IFU_MISALIGN_CHECK_EN
    , .inst_misalign(inst_misalign)
`endif
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] data; logic mis; } exp_t;
  typedef struct { logic [31:0] addr; int due; } req_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_del  = 0;
  int   n_req  = 0;
  int   lat    = 1;
  bit   rdy_toggle = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = base + 32'(4 * i);
      e.data = mem_word(e.pc);
      e.mis  = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("rst_inst_misalign", {31'b0, inst_misalign}, 32'd0);
`endif
    repeat (3) next_cycle();
    exp_q.delete();
    n_del = 0;
    n_req = 0;
    rst = 1'b0;
  endtask

  // Memory: accepts per ready pattern, answers in order after `lat` cycles.
  initial begin : mem_model
    req_t        fl[$];
    int          cyc;
    logic        prev_stall;
    logic [31:0] prev_addr;
    cyc = 0;
    prev_stall = 1'b0;
    prev_addr = 32'd0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      imem_req_ready = rdy_toggle ? ~imem_req_ready : 1'b1;
      if (fl.size() > 0 && fl[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(fl[0].addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'd0;
      end
      @(negedge clk);
      if (rst) begin
        fl.delete();
        prev_stall = 1'b0;
      end else begin
        if (rdy_toggle && prev_stall) chk("addr_hold", imem_req_addr, prev_addr);
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
        if (imem_resp_valid) void'(fl.pop_front());
        if (imem_req_valid && imem_req_ready) begin
          fl.push_back('{imem_req_addr, cyc + lat});
          n_req++;
        end
      end
    end
  end

  // Decode-side scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready) begin
        n_del++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_inst observed=%0h expected=none", inst_pc);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_data", inst_data, e.data);
`ifdef IFU_MISALIGN_CHECK_EN
          chk("inst_misalign", {31'b0, inst_misalign}, {31'b0, e.mis});
`endif
        end
      end
    end
  end

  initial begin : stimulus
    int   occ, max_occ, nreq_snap;
    exp_t f;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    inst_ready = 1'b1;

    // Streaming at 1-cycle latency
    lat = 1;
    do_reset();
    push_seq(32'h0, 64);
    @(negedge clk);
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0000_0000);
    next_cycle(); @(negedge clk);
    chk("c1_inst_valid", {31'b0, inst_valid}, 32'd0);
    next_cycle(); @(negedge clk);
    chk("c2_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("c2_inst_pc", inst_pc, 32'h0000_0000);
    repeat (20) next_cycle();
    chk("stream_throughput", {31'b0, n_del >= 8}, 32'd1);

    // Decode stall for 10 cycles
    inst_ready = 1'b0;
    do_reset();
    push_seq(32'h0, 64);
    max_occ = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      occ = n_req - n_del;
      if (occ > max_occ) max_occ = occ;
    end
    chk("stall_max_occupancy", 32'(max_occ), 32'd2);
    inst_ready = 1'b1;
    next_cycle();
    next_cycle();
    chk("release_back_to_back", 32'(n_del), 32'd2);
    repeat (10) next_cycle();
    inst_ready = 1'b0;
    repeat (3) next_cycle();

    // Toggling memory ready, 2-cycle latency (reset lands on a full buffer)
    inst_ready = 1'b1;
    rdy_toggle = 1'b1;
    lat = 2;
    do_reset();
    push_seq(32'h0, 64);
    repeat (30) next_cycle();
    chk("toggle_throughput", {31'b0, n_del >= 5}, 32'd1);
    rdy_toggle = 1'b0;

    // Redirect with two responses in flight at 3-cycle latency
    lat = 3;
    do_reset();
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    push_seq(32'h100, 32);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("drain_no_req_c3", {31'b0, imem_req_valid}, 32'd0);
    next_cycle(); @(negedge clk);
    chk("drain_no_req_c4", {31'b0, imem_req_valid}, 32'd0);
    next_cycle(); @(negedge clk);
    chk("post_drain_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("post_drain_req_addr", imem_req_addr, 32'h0000_0100);
    repeat (20) next_cycle();
    chk("post_drain_delivered", {31'b0, n_del >= 3}, 32'd1);

    // Redirect coinciding with a response and a decode pop
    lat = 1;
    do_reset();
    push_seq(32'h0, 1);
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    push_seq(32'h100, 32);
    @(negedge clk);
    chk("same_cycle_resp", {31'b0, imem_resp_valid}, 32'd1);
    chk("same_cycle_pop", {31'b0, inst_valid}, 32'd1);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("flushed_empty", {31'b0, inst_valid}, 32'd0);
    chk("flushed_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("flushed_req_addr", imem_req_addr, 32'h0000_0100);
    repeat (10) next_cycle();
    chk("flushed_delivered", {31'b0, n_del >= 4}, 32'd1);

`ifdef IFU_MISALIGN_CHECK_EN
    // Misaligned redirect: single fault entry, halt, then resume
    do_reset();
    push_seq(32'h0, 1);
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    f.pc = 32'h0000_0102;
    f.data = 32'h0;
    f.mis = 1'b1;
    exp_q.push_back(f);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("halt_no_req", {31'b0, imem_req_valid}, 32'd0);
    chk("halt_empty_c3", {31'b0, inst_valid}, 32'd0);
    next_cycle(); @(negedge clk);
    chk("fault_valid", {31'b0, inst_valid}, 32'd1);
    chk("fault_flag", {31'b0, inst_misalign}, 32'd1);
    nreq_snap = n_req;
    repeat (8) next_cycle();
    chk("halt_no_requests", 32'(n_req), 32'(nreq_snap));
    chk("halt_single_entry", 32'(n_del), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    push_seq(32'h200, 32);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("resume_req_addr", imem_req_addr, 32'h0000_0200);
    repeat (10) next_cycle();
    chk("resume_delivered", {31'b0, n_del >= 5}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the RV32I core. It sits directly upstream of decode and immediate generation. It owns the program counter and issues word reads to instruction memory over a valid/ready request channel. In-order responses are buffered in a small FIFO and presented to decode as a valid/ready stream of `{instruction, pc}` pairs. A redirect port lets execute steer fetch on branches and jumps; responses already in flight at redirect time are discarded.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset
- `DEPTH`, 2, instruction buffer entries; must be a power of two, ≥2
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word address (bits [1:0] always 0)
- `imem_resp_valid`  in  1  response data valid; in order, latency ≥1 cycle
- `imem_resp_data`  in  32  fetched instruction word
- `redirect_valid`  in  1  take new PC (branch/jump/trap)
- `redirect_pc`  in  32  new PC
- `inst_valid`  out  1  buffer head valid toward decode
- `inst_ready`  in  1  decode consumes head
- `inst_data`  out  32  instruction word to decode / immediate generator
- `inst_pc`  out  32  PC of `inst_data`
- `inst_misalign`  out  1  head is a misaligned-target fault (present only with `IFU_MISALIGN_CHECK_EN`)

## Operation
- Registers:
  - `pc`: next fetch address.
  - `outstanding`: accepted requests not yet answered.
  - `stale`: responses to discard.
  - FIFO: `DEPTH` entries of `{data, pc}`, plus a per-entry `misalign` bit when the macro is defined.
  - A pc FIFO records each issued request address so it can be paired with its response.
- Credit rule: `imem_req_valid` = (state==FETCH) && (fifo_count + outstanding < DEPTH). Requests are therefore never issued without a guaranteed buffer slot.
- On a request handshake (valid && ready): push `pc` into the request-pc queue, `outstanding`++, and `pc` += 4.
- On a response (`imem_resp_valid`):
  - If `stale`>0: `stale`--, drop the data, `outstanding`--.
  - Else: write `{imem_resp_data, popped pc}` into the FIFO, `outstanding`--.
- Decode handshake (`inst_valid && inst_ready`): pop the FIFO head.
- State machine:
  - FETCH: normal operation, requests enabled.
  - DRAIN: no requests issued; entered on redirect when in-flight responses remain. Exit to FETCH in the cycle `stale` reaches 0.
  - HALT: only with macro; no requests issued.
- Redirect (highest priority, any state):
  - Flush FIFO and request-pc queue.
  - `pc` ← `redirect_pc`.
  - `stale` ← `outstanding` (after same-cycle updates). This count includes a request accepted in the same cycle, and excludes a response arriving in the same cycle, which is itself dropped.
  - Next state is DRAIN if `stale`>0, else FETCH.
  - A pop by decode in the redirect cycle is harmless.
- Simultaneous push and pop on the FIFO keeps the count unchanged; full and empty are never overrun because of the credit rule.
- `pc` wraps from 32'hFFFF_FFFC to 0 with no flag.

## Timing
- Reset values: `pc`=`RESET_PC`, `outstanding`=`stale`=0, FIFO empty, state FETCH.
- Output values during reset: `inst_valid`=0, `inst_misalign`=0, `inst_data`=0, `inst_pc`=0, `imem_req_valid`=0.
- `rst` asserted mid-operation wins over every other input; responses arriving after reset deasserts are undefined and must be prevented by the system.
- First request: in the first cycle after `rst` deasserts, with `imem_req_addr`=`RESET_PC`.
- Latency: a response in cycle N appears on `inst_valid`/`inst_data` in cycle N+1, driven from registers with no bypass.
- Redirect in cycle N: the first request with the new address appears in cycle N+1 if nothing is in flight, otherwise in the cycle after the last stale response arrives.
- `imem_req_addr` equals `pc` and holds stable while valid && !ready.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 flushes as usual, then enters HALT after any drain.
  - In HALT, one FIFO entry is written with `inst_misalign`=1, `inst_data`=0, `inst_pc`=`redirect_pc`.
  - No further requests are issued until the next aligned redirect.
  - A misaligned redirect while in HALT re-arms the same fault entry.
- Not defined:
  - The `inst_misalign` port is absent and HALT does not exist.
  - `redirect_pc[1:0]` is ignored and forced to 0.

## Test plan
- Reset release, memory with 1-cycle latency and always ready:
  - Requests go to 0x0, 0x4, 0x8…
  - `inst_valid` first rises 2 cycles after the first request.
  - `inst_pc` values increment by 4.
- Stall decode with `inst_ready`=0 for 10 cycles, `DEPTH`=2:
  - At most 2 requests are outstanding or buffered, with no overrun.
  - After release, the order is 0x0, 0x4 with no gaps.
- Memory `imem_req_ready` toggling every other cycle:
  - Address holds while not ready.
  - The instruction stream has no duplicates or skips.
- Redirect to 0x100 with 2 responses in flight at 3-cycle latency:
  - Both stale words are dropped.
  - The next delivered `inst_pc` is 0x100.
  - No request is issued while in DRAIN.
- Redirect in the same cycle as a response and a decode pop:
  - The response is discarded and the FIFO is empty next cycle.
  - The fetch of 0x100 follows.
- With macro, redirect to 0x102:
  - One entry is delivered with `inst_misalign`=1 and `inst_pc`=0x102.
  - No requests are issued afterwards.
  - A redirect to 0x200 resumes fetch.
